data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: the maximum number of cycles spent in ACCESS before a bus error is declared.
REQ-002 SHALL have ports CLK (in, 1), the single clock, with all state on its rising edge.
REQ-003 SHALL have RESET (in, 1), asynchronous, active-high.
REQ-004 SHALL have MEM_READ (in, 1) and MEM_WRITE (in, 1): the load/store request from the EX/MEM stage, held until BUSYWAIT is low at a clock edge.
REQ-005 SHALL have FUNC3 (in, 3): access size and sign; ADDRESS (in, 32): byte address; WRITE_DATA (in, 32): store data, right-aligned.
REQ-006 SHALL have READ_DATA (out, 32): extended load result; BUSYWAIT (out, 1): pipeline stall; FAULT (out, 1): misaligned, illegal or timed-out access.
REQ-007 SHALL have MEM_REQ (out, 1), MEM_WE (out, 1), MEM_ADDR (out, 32, bits[1:0]=00), MEM_WDATA (out, 32), MEM_BE (out, 4): the word-wide backing-memory request.
REQ-008 SHALL have MEM_RDATA (in, 32) and MEM_ACK (in, 1): the backing-memory response.

Function
REQ-009 SHALL implement states IDLE, ACCESS and DONE.
REQ-010 IDLE: a legal request (exactly one of MEM_READ/MEM_WRITE high, legal FUNC3, aligned) SHALL drive BUSYWAIT high combinationally in the same cycle and go to ACCESS at the next edge.
REQ-011 ACCESS: MEM_REQ SHALL be high, with MEM_WE, MEM_ADDR, MEM_BE and MEM_WDATA registered and stable; BUSYWAIT SHALL be high; MEM_ACK high SHALL capture MEM_RDATA and go to DONE.
REQ-012 DONE: BUSYWAIT SHALL be low and MEM_REQ low for exactly one cycle, with READ_DATA valid; the next state SHALL be IDLE unconditionally.
REQ-013 Legal FUNC3 for loads SHALL be 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores, 000 SB, 001 SH, 010 SW.
REQ-014 Misaligned (halfword with ADDRESS[0]=1; word with ADDRESS[1:0]!=00), illegal FUNC3, or both MEM_READ and MEM_WRITE high SHALL assert FAULT combinationally in IDLE, keep BUSYWAIT low, and issue no MEM_REQ.
REQ-015 Store lanes SHALL be MEM_BE: SB = 0001 shifted left by ADDRESS[1:0]; SH = 0011 shifted left by ADDRESS[1:0]; SW = 1111. The data byte or halfword SHALL be replicated into the selected lanes.
REQ-016 Loads SHALL select a byte or halfword from the captured word by ADDRESS[1:0], sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-017 A cycle counter SHALL count ACCESS cycles; reaching ACK_TIMEOUT without MEM_ACK SHALL go to DONE with FAULT high in DONE and READ_DATA = 0.
REQ-018 MEM_ACK outside ACCESS SHALL be ignored.
REQ-019 MEM_ACK in the first ACCESS cycle SHALL give minimum latency: one BUSYWAIT cycle in IDLE plus one in ACCESS, then DONE.
REQ-020 Back-to-back requests SHALL be supported: a new request present in the IDLE cycle after DONE SHALL start immediately.
REQ-021 READ_DATA SHALL hold its last value outside DONE.

Reset
REQ-022 RESET high SHALL asynchronously force IDLE, counter = 0, READ_DATA = 0, MEM_REQ = 0, MEM_WE = 0, MEM_BE = 0000, MEM_ADDR = 0 and MEM_WDATA = 0.
REQ-023 With RESET high, BUSYWAIT and FAULT SHALL be 0.
REQ-024 Reset during ACCESS SHALL drop MEM_REQ immediately and discard the transaction; a late MEM_ACK SHALL be ignored.

Structure
REQ-025 The FUNC3 load/store encodings and the state encoding SHALL live in the shared package cpu_pkg.
REQ-026 Load extraction and extension SHALL be one combinational sub-module, load_align.
REQ-027 Store lane and data generation SHALL remain inline.

Verification
REQ-028 SW, ADDRESS=0x100, WRITE_DATA=0xDEADBEEF, MEM_ACK after 3 cycles -> MEM_BE=1111 and MEM_ADDR=0x100; BUSYWAIT high for 4 cycles, then low for 1.
REQ-029 SB, ADDRESS=0x103, WRITE_DATA=0x000000A5 -> MEM_BE=1000 and MEM_WDATA=0xA5A5A5A5.
REQ-030 LB vs LBU, ADDRESS=0x202, MEM_RDATA=0x12F0_3456 -> READ_DATA=0xFFFFFFF0 (LB) and 0x000000F0 (LBU).
REQ-031 LW, ADDRESS=0x102 -> FAULT high, BUSYWAIT low, no MEM_REQ.
REQ-032 LH, MEM_ACK never asserted, ACK_TIMEOUT=4 -> DONE after 4 ACCESS cycles, with FAULT=1 and READ_DATA=0.
REQ-033 RESET pulse in the second ACCESS cycle, then MEM_ACK -> MEM_REQ=0 immediately, state IDLE, READ_DATA unchanged at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the data-memory path.
//   - state_e    : data_mem_ctrl FSM states (IDLE, ACCESS, DONE)
//   - F3_*       : load/store FUNC3 encodings
//   - f3_legal   : FUNC3 legality for loads vs stores
//   - f3_aligned : address alignment check for the access size in FUNC3
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // FUNC3[1:0] encodes the access size for every legal code.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (addr_lo[0] == 1'b0);
            2'b10:   ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts a byte/halfword/word from a memory word and extends it.
//   word     (in, 32) : word returned by the backing memory
//   func3    (in, 3)  : load type (LB, LH, LW, LBU, LHU)
//   byte_off (in, 2)  : byte offset within the word
//   data     (out, 32): sign- or zero-extended load result
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  func3,
    input  logic [1:0]  byte_off,
    output logic [31:0] data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = word[7:0];
        case (byte_off)
            2'd0: sel_b = word[7:0];
            2'd1: sel_b = word[15:8];
            2'd2: sel_b = word[23:16];
            2'd3: sel_b = word[31:24];
            default: sel_b = word[7:0];
        endcase
        sel_h = byte_off[1] ? word[31:16] : word[15:0];

        data = word;
        case (func3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_BU:   data = {24'd0, sel_b};
            F3_HU:   data = {16'd0, sel_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit between the EX/MEM stage and a word-wide memory.
//   CLK, RESET            : clock (rising edge), async active-high reset
//   MEM_READ, MEM_WRITE   : pipeline load/store request, held while BUSYWAIT
//   FUNC3, ADDRESS        : access type and byte address
//   WRITE_DATA            : right-aligned store data
//   READ_DATA             : extended load result, valid in DONE, held otherwise
//   BUSYWAIT              : pipeline stall
//   FAULT                 : misaligned/illegal request (IDLE) or ack timeout (DONE)
//   MEM_REQ/WE/ADDR/WDATA/BE : registered backing-memory request
//   MEM_RDATA, MEM_ACK    : backing-memory response
module data_mem_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        FAULT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BE,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          req_any, req_ok, req_bad;
    logic          timeout_hit;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   load_data;

    assign req_any = MEM_READ | MEM_WRITE;
    assign req_ok  = (MEM_READ ^ MEM_WRITE) && f3_legal(FUNC3, MEM_WRITE)
                     && f3_aligned(FUNC3, ADDRESS[1:0]);
    assign req_bad = req_any && !req_ok;

    assign timeout_hit = !MEM_ACK && (cnt_q == CNT_LAST);

    // Reset gates the combinational handshake outputs so a request held
    // through reset cannot raise BUSYWAIT or FAULT.
    assign BUSYWAIT = !RESET && (((state_q == IDLE) && req_ok) || (state_q == ACCESS));
    assign FAULT    = !RESET && (((state_q == IDLE) && req_bad)
                                 || ((state_q == DONE) && timeout_q));

    // Store lanes and replicated data.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WRITE_DATA;
        case (FUNC3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ADDRESS[1:0];
                wdata_d = {4{WRITE_DATA[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << ADDRESS[1:0];
                wdata_d = {2{WRITE_DATA[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WRITE_DATA;
            end
        endcase
    end

    load_align u_load_align (
        .word     (MEM_RDATA),
        .func3    (f3_q),
        .byte_off (off_q),
        .data     (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_ok) state_d = ACCESS;
            ACCESS:  if (MEM_ACK || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            READ_DATA <= '0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_BE    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    timeout_q <= 1'b0;
                    if (req_ok) begin
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= MEM_WRITE;
                        MEM_ADDR  <= {ADDRESS[31:2], 2'b00};
                        MEM_BE    <= be_d;
                        MEM_WDATA <= MEM_WRITE ? wdata_d : '0;
                        f3_q      <= FUNC3;
                        off_q     <= ADDRESS[1:0];
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (MEM_ACK) begin
                        MEM_REQ <= 1'b0;
                        if (!MEM_WE) READ_DATA <= load_data;
                    end else if (timeout_hit) begin
                        MEM_REQ   <= 1'b0;
                        READ_DATA <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    cnt_q     <= '0;
                    timeout_q <= 1'b0;
                end
                default: begin
                    cnt_q   <= '0;
                    MEM_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
